// File: rtl/rob_if.sv
// rob_if: dispatch / rename, writeback and commit signals of the reorder buffer.
//
// Signal names keep the i_/o_ prefixes as seen from the ROB itself:
//   dispatch  : i_disp_valid, i_disp_dst, o_disp_ready
//   rename    : o_rat_valid, o_rat_addr (allocated tag), o_rat_dst_addr
//   writeback : i_wb_valid, i_wb_tag, i_wb_data
//   commit    : o_cmt_valid, o_cmt_tag, o_cmt_dst, o_cmt_data
//   status    : o_full, o_empty, o_count
// Modports: slave is the ROB, master is the surrounding pipeline / bench.
`timescale 1ns/1ps
interface rob_if #(
    parameter int AW = 2,
    parameter int RW = 2,
    parameter int DW = 16
);
    logic          i_disp_valid;
    logic [RW-1:0] i_disp_dst;
    logic          o_disp_ready;
    logic          o_rat_valid;
    logic [AW-1:0] o_rat_addr;
    logic [RW-1:0] o_rat_dst_addr;
    logic          i_wb_valid;
    logic [AW-1:0] i_wb_tag;
    logic [DW-1:0] i_wb_data;
    logic          o_cmt_valid;
    logic [AW-1:0] o_cmt_tag;
    logic [RW-1:0] o_cmt_dst;
    logic [DW-1:0] o_cmt_data;
    logic          o_full;
    logic          o_empty;
    logic [AW:0]   o_count;

    modport slave (
        input  i_disp_valid, i_disp_dst, i_wb_valid, i_wb_tag, i_wb_data,
        output o_disp_ready, o_rat_valid, o_rat_addr, o_rat_dst_addr,
        output o_cmt_valid, o_cmt_tag, o_cmt_dst, o_cmt_data,
        output o_full, o_empty, o_count
    );

    modport master (
        output i_disp_valid, i_disp_dst, i_wb_valid, i_wb_tag, i_wb_data,
        input  o_disp_ready, o_rat_valid, o_rat_addr, o_rat_dst_addr,
        input  o_cmt_valid, o_cmt_tag, o_cmt_dst, o_cmt_data,
        input  o_full, o_empty, o_count
    );
endinterface

// File: rtl/rob.sv
// rob: small in-order-retire reorder buffer placed in front of the RAT.
//
// Each dispatched instruction gets the tail tag; the rename write (tag,
// destination) goes to the RAT combinationally in the same cycle. Results
// arrive out of order on the writeback bus and entries retire strictly in
// program order, one per cycle, through registered o_cmt_* outputs.
//
// Ports:
//   i_clk   clock, rising edge
//   i_rstn  asynchronous active-low reset
//   i_flush (only with ROB_FLUSH_EN) discard all entries, highest priority
//   bus     rob_if.slave, dispatch / rename / writeback / commit / status
//
// Optional feature macro: ROB_FLUSH_EN (adds i_flush and the flush path).
`timescale 1ns/1ps
module rob #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int RW    = 2,
    parameter int DW    = 16
) (
    input  logic   i_clk,
    input  logic   i_rstn,
`ifdef ROB_FLUSH_EN
    input  logic   i_flush,
`endif
    rob_if.slave   bus
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    // Entry state: control bits are reset, payload lives in plain arrays.
    logic [DEPTH-1:0] valid_reg, valid_next;
    logic [DEPTH-1:0] done_reg,  done_next;
    logic [RW-1:0]    dst_reg  [DEPTH];
    logic [DW-1:0]    data_reg [DEPTH];

    logic [AW-1:0]    head_reg, tail_reg;
    logic [AW:0]      count_reg, count_next;

    logic             cmt_valid_reg;
    logic [AW-1:0]    cmt_tag_reg;
    logic [RW-1:0]    cmt_dst_reg;
    logic [DW-1:0]    cmt_data_reg;

    logic             flush;
    logic             full;
    logic             accept;
    logic             wb_accept;
    logic             commit;
    logic [DEPTH-1:0] alloc_hit, wb_hit, cmt_hit;

`ifdef ROB_FLUSH_EN
    assign flush = i_flush;
`else
    assign flush = 1'b0;
`endif

    // Ready depends only on the current count: a commit on the same edge
    // does not open a slot for a dispatch in this cycle.
    assign full   = (count_reg == FULL_CNT);
    assign accept = bus.i_disp_valid && !full && !flush;

    // The tail entry is never valid while not full, so a writeback aimed at
    // the tag being allocated this cycle is dropped by the valid check.
    assign wb_accept = bus.i_wb_valid && valid_reg[bus.i_wb_tag]
                       && !done_reg[bus.i_wb_tag] && !flush;

    // Commit looks only at registered done bits, so a writeback needs one
    // full edge before the entry can retire.
    assign commit = valid_reg[head_reg] && done_reg[head_reg] && !flush;

    // Allocation (tail, invalid entry), completion (valid, not done) and
    // retirement (head, done) can never target the same entry on one edge.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        assign alloc_hit[gi] = accept    && (tail_reg        == AW'(gi));
        assign wb_hit[gi]    = wb_accept && (bus.i_wb_tag    == AW'(gi));
        assign cmt_hit[gi]   = commit    && (head_reg        == AW'(gi));

        assign valid_next[gi] = flush         ? 1'b0 :
                                cmt_hit[gi]   ? 1'b0 :
                                alloc_hit[gi] ? 1'b1 :
                                                valid_reg[gi];

        assign done_next[gi]  = flush         ? 1'b0 :
                                cmt_hit[gi]   ? 1'b0 :
                                alloc_hit[gi] ? 1'b0 :
                                wb_hit[gi]    ? 1'b1 :
                                                done_reg[gi];
    end

    always_comb begin
        count_next = count_reg;
        if (flush) begin
            count_next = '0;
        end else begin
            count_next = count_reg + {{AW{1'b0}}, accept} - {{AW{1'b0}}, commit};
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            valid_reg     <= '0;
            done_reg      <= '0;
            head_reg      <= '0;
            tail_reg      <= '0;
            count_reg     <= '0;
            cmt_valid_reg <= 1'b0;
            cmt_tag_reg   <= '0;
            cmt_dst_reg   <= '0;
            cmt_data_reg  <= '0;
        end else begin
            valid_reg     <= valid_next;
            done_reg      <= done_next;
            count_reg     <= count_next;
            cmt_valid_reg <= commit;
            if (flush) begin
                head_reg <= '0;
                tail_reg <= '0;
            end else begin
                if (accept) begin
                    tail_reg <= tail_reg + AW'(1);
                end
                if (commit) begin
                    head_reg     <= head_reg + AW'(1);
                    cmt_tag_reg  <= head_reg;
                    cmt_dst_reg  <= dst_reg[head_reg];
                    cmt_data_reg <= data_reg[head_reg];
                end
            end
        end
    end

    // Payload storage: no reset needed, the valid/done bits gate every use.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            dst_reg[tail_reg] <= bus.i_disp_dst;
        end
        if (wb_accept) begin
            data_reg[bus.i_wb_tag] <= bus.i_wb_data;
        end
    end

    assign bus.o_disp_ready   = !full;
    assign bus.o_rat_valid    = accept;
    assign bus.o_rat_addr     = tail_reg;
    assign bus.o_rat_dst_addr = bus.i_disp_dst;
    assign bus.o_cmt_valid    = cmt_valid_reg;
    assign bus.o_cmt_tag      = cmt_tag_reg;
    assign bus.o_cmt_dst      = cmt_dst_reg;
    assign bus.o_cmt_data     = cmt_data_reg;
    assign bus.o_full         = full;
    assign bus.o_empty        = (count_reg == '0);
    assign bus.o_count        = count_reg;
endmodule

// File: doc/rob.md
# rob

Four-entry reorder buffer that sits directly upstream of the register alias table (RAT). It allocates a ROB tag for each dispatched instruction and presents the rename write (tag, destination register) to the RAT in the same cycle. It collects out-of-order results from the writeback bus and retires entries strictly in program order, at most one per cycle, to the architectural register file.

## Interface

Parameters:
- DEPTH, 4: number of entries; power of two.
- AW, 2: tag width, log2(DEPTH).
- RW, 2: architectural register address width.
- DW, 16: result data width.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rstn  in  1  reset; asynchronous, active-low.
- i_disp_valid  in  1  dispatch request.
- i_disp_dst  in  RW  destination architectural register of the dispatched instruction.
- o_disp_ready  out  1  combinational; equals !o_full.
- o_rat_valid  out  1  combinational; i_disp_valid & o_disp_ready (rename write to RAT).
- o_rat_addr  out  AW  combinational; allocated tag (tail pointer).
- o_rat_dst_addr  out  RW  combinational; copy of i_disp_dst.
- i_wb_valid  in  1  writeback bus valid.
- i_wb_tag  in  AW  tag being completed.
- i_wb_data  in  DW  result value.
- o_cmt_valid  out  1  registered; one-cycle commit pulse.
- o_cmt_tag  out  AW  registered; retired tag.
- o_cmt_dst  out  RW  registered; retired destination register.
- o_cmt_data  out  DW  registered; retired value.
- o_full  out  1  combinational; count == DEPTH.
- o_empty  out  1  combinational; count == 0.
- o_count  out  AW+1  registered occupancy.
- i_flush  in  1  present only with ROB_FLUSH_EN.

## Operation

- Per entry: valid, done, dst[RW], data[DW]. Pointers head, tail (AW bits, wrap modulo DEPTH). Count is AW+1 bits.
- Dispatch: accepted when i_disp_valid && !o_full. On the edge: entry[tail] gets valid=1, done=0, dst=i_disp_dst; tail increments.
- Writeback: if i_wb_valid and entry[i_wb_tag].valid && !done, then done=1 and data=i_wb_data. Writeback to an invalid or already-done entry is ignored (first write wins).
- Commit: if entry[head].valid && done, the entry is cleared, head increments, and o_cmt_* load {1, head, dst, data}. Otherwise o_cmt_valid loads 0.
- Occupancy: count_next = count + accept − commit. Dispatch and commit may occur in the same cycle.
- Reset (async): all valid/done bits, head, tail, count, and all o_cmt_* outputs are 0. After reset: o_empty=1, o_full=0, o_disp_ready=1.

## Timing

- Dispatch to RAT: zero latency. o_rat_* is valid in the same cycle as i_disp_valid; the RAT captures it on the same edge that allocates the entry.
- Writeback to commit: writeback registered at edge N makes the head entry eligible; commit occurs at edge N+1, and o_cmt_valid is high during the cycle after N+1. Writeback cannot be combinationally forwarded to commit.
- Throughput: one dispatch, one writeback, and one commit per cycle, concurrently.
- Full: o_disp_ready is computed from the current count. A dispatch is rejected while full even if a commit happens on the same edge.
- Writeback with i_wb_tag equal to the current tail (unallocated) is ignored, even with a simultaneous dispatch to that tag.
- Head and tail wrap 3→0. Full versus empty is distinguished only by count.

## Configuration

- ROB_FLUSH_EN defined: port i_flush exists. When i_flush=1 on an edge, it has highest priority:
  - all valid/done bits, head, tail, and count are cleared, and o_cmt_valid loads 0;
  - a same-cycle dispatch and writeback are dropped, and o_rat_valid is forced to 0 while i_flush=1.
- ROB_FLUSH_EN undefined: no i_flush port and no flush logic. Entries leave only by commit.

## Test plan

- Reset: pulse i_rstn low for 50 ns mid-operation with 2 entries live -> o_count=0, o_empty=1, o_cmt_valid=0, o_disp_ready=1 immediately while low.
- Rename: dispatch dst 0, 3, 2 on consecutive cycles -> o_rat_valid=1 with o_rat_addr 0, 1, 2 and o_rat_dst_addr 0, 3, 2; o_count=3.
- Out-of-order completion: after the rename scenario, writeback tag1=0x1111, then tag0=0xAAAA -> commits {tag0, dst0, 0xAAAA} then {tag1, dst3, 0x1111} on consecutive cycles; tag2 does not commit until written.
- Full/wrap: dispatch 4 entries -> o_full=1, o_disp_ready=0; a 5th dispatch gives o_rat_valid=0 and count stays 4. Complete and commit tag0, then dispatch -> o_rat_addr=0.
- Simultaneous: with count=2, dispatch and commit in the same cycle -> count stays 2, tail and head each advance by 1. A writeback to an invalid tag leaves state unchanged.
- Flush (ROB_FLUSH_EN): 3 entries live, assert i_flush for one cycle -> o_empty=1 next cycle. The next dispatch gets tag 0. A late writeback to old tag 1 is ignored.
